// File: rtl/plru_tree_replace_pkg.sv
// Shared types and default geometry for the tree pseudo-LRU replacement unit.
package plru_tree_replace_pkg;

   localparam int unsigned PLRU_DEF_WAYS = 4;
   localparam int unsigned PLRU_DEF_SETS = 8;

   // Legacy 4-way tree state, {root, left, right}.
   typedef logic [2:0] lc3b_plru4;

endpackage

// File: rtl/plru_victim_sel.sv
// Combinational victim picker: lowest invalid way first, otherwise walk the PLRU tree.
module plru_victim_sel
   import plru_tree_replace_pkg::*;
#(
   parameter int unsigned WAYS  = PLRU_DEF_WAYS,
   parameter int unsigned WAY_W = $clog2(WAYS)
) (
   input  logic [WAYS-2:0]  tree,
   input  logic [WAYS-1:0]  way_valid,
   output logic [WAYS-1:0]  victim_way_c,
   output logic [WAY_W-1:0] victim_idx_c
);

   int unsigned      node;
   logic [WAY_W-1:0] pos;

   // Heap node k lives at tree bit WAYS-1-k; the leaf reached is node WAYS+way.
   always_comb begin
      node = 1;
      pos  = '0;
      for (int unsigned l = 0; l < WAY_W; l++) begin
         pos  = WAY_W'(WAYS - 1 - node);
         node = 2 * node + 32'(tree[pos]);
      end
      victim_idx_c = WAY_W'(node - WAYS);
      for (int i = int'(WAYS) - 1; i >= 0; i--) begin
         if (!way_valid[i]) victim_idx_c = WAY_W'(i);
      end
      victim_way_c = WAYS'(1) << victim_idx_c;
   end

endmodule

// File: rtl/plru_tree_replace.sv
// Per-set tree pseudo-LRU state with touch update and a registered one-hot victim.
module plru_tree_replace
   import plru_tree_replace_pkg::*;
#(
   parameter int unsigned WAYS  = PLRU_DEF_WAYS,
   parameter int unsigned SETS  = PLRU_DEF_SETS,
   parameter int unsigned IDX_W = $clog2(SETS),
   parameter int unsigned WAY_W = $clog2(WAYS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             touch_valid,
   input  logic [IDX_W-1:0] touch_set,
   input  logic [WAYS-1:0]  touch_way,
   input  logic             query_valid,
   input  logic [IDX_W-1:0] query_set,
   input  logic [WAYS-1:0]  way_valid,
   output logic             victim_valid,
   output logic [WAYS-1:0]  victim_way,
   output logic [WAY_W-1:0] victim_idx,
   output logic             touch_err
);

   logic [WAYS-2:0]  tree_q [SETS];
   logic [WAYS-2:0]  tree_upd_c;
   logic [WAYS-2:0]  query_tree_c;
   logic [WAY_W-1:0] touch_idx_c;
   logic [WAY_W-1:0] idx_sh;
   logic [WAY_W-1:0] pos;
   int unsigned      node;
   logic             touch_onehot_c;
   logic             touch_ok_c;
   logic [WAYS-1:0]  sel_way_c;
   logic [WAY_W-1:0] sel_idx_c;

   assign touch_onehot_c = $onehot(touch_way);
   assign touch_ok_c     = touch_valid && touch_onehot_c && !flush;

   always_comb begin
      touch_idx_c = '0;
      for (int unsigned i = 0; i < WAYS; i++) begin
         if (touch_way[i]) touch_idx_c = WAY_W'(i);
      end
   end

   // Walk the path to the touched way MSB-first, pointing each node at the other half.
   always_comb begin
      tree_upd_c = tree_q[touch_set];
      idx_sh     = touch_idx_c;
      node       = 1;
      pos        = '0;
      for (int unsigned l = 0; l < WAY_W; l++) begin
         pos             = WAY_W'(WAYS - 1 - node);
         tree_upd_c[pos] = ~idx_sh[WAY_W-1];
         node            = 2 * node + 32'(idx_sh[WAY_W-1]);
         idx_sh          = idx_sh << 1;
      end
   end

   // Flush wins over a same-cycle touch; same-set touch is bypassed into the query.
   always_comb begin
      query_tree_c = tree_q[query_set];
      if (flush) begin
         query_tree_c = '0;
      end else if (touch_ok_c && (touch_set == query_set)) begin
         query_tree_c = tree_upd_c;
      end
   end

   plru_victim_sel #(
      .WAYS  (WAYS),
      .WAY_W (WAY_W)
   ) u_victim_sel (
      .tree         (query_tree_c),
      .way_valid    (way_valid),
      .victim_way_c (sel_way_c),
      .victim_idx_c (sel_idx_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned s = 0; s < SETS; s++) tree_q[s] <= '0;
      end else if (flush) begin
         for (int unsigned s = 0; s < SETS; s++) tree_q[s] <= '0;
      end else if (touch_ok_c) begin
         tree_q[touch_set] <= tree_upd_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         victim_valid <= 1'b0;
         victim_way   <= '0;
         victim_idx   <= '0;
         touch_err    <= 1'b0;
      end else begin
         victim_valid <= query_valid;
         touch_err    <= touch_valid && !touch_onehot_c;
         if (query_valid) begin
            victim_way <= sel_way_c;
            victim_idx <= sel_idx_c;
         end
      end
   end

endmodule

// File: doc/plru_tree_replace.md
# plru_tree_replace

Parametrised tree pseudo-LRU replacement unit for the set-associative caches. It holds per-set PLRU tree state for SETS sets and WAYS ways, updates the state on every hit or fill, and returns a registered one-hot victim for a miss. Invalid ways are always chosen before the tree is consulted. It sits beside the tag/valid arrays in the cache datapath, and the cache controller drives it.

## Interface
Parameters:
- WAYS, 4, number of ways; power of 2, range 2..16
- SETS, 8, number of sets; power of 2, at least 2
- IDX_W, $clog2(SETS), set index width (derived; do not override)
- WAY_W, $clog2(WAYS), encoded way width (derived)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all tree state
- touch_valid  in  1  access (hit or fill) this cycle
- touch_set  in  IDX_W  set accessed
- touch_way  in  WAYS  one-hot way accessed
- query_valid  in  1  victim request this cycle
- query_set  in  IDX_W  set needing a victim
- way_valid  in  WAYS  valid bits of query_set, from the tag arrays
- victim_valid  out  1  one-cycle pulse; victim outputs are valid
- victim_way  out  WAYS  one-hot victim
- victim_idx  out  WAY_W  encoded victim
- touch_err  out  1  one-cycle pulse; touch_way was not one-hot

## Operation
- Each set stores WAYS-1 tree bits, organised as a heap: node 1 is the root, and node k has children 2k and 2k+1.
- Node k is stored at state bit WAYS-1-k. For WAYS=4 the vector {root, left, right} matches the legacy 3-bit 4-way encoding.
- Bit value: 0 means the LRU side is the left (lower ways); 1 means the right.
- Victim selection when all ways are valid: walk from the root, following each bit, to a leaf.
- Victim selection when any way_valid bit is 0: choose the lowest-index invalid way. The tree is ignored.
- Touch: for each node on the path to the touched way, set the bit to point away from that way. Went left, write 1; went right, write 0. Other nodes are unchanged.
- touch_valid with a non-one-hot touch_way (zero or multi-hot): no state change, and touch_err pulses.
- Priority: rst_n, then flush, then touch. flush with touch_valid in the same cycle: the touch is dropped.
- Reset and flush set all tree bits to 0, so an empty-history set picks way 0.

## Timing
- Query latency is 1 cycle. query_valid in cycle N gives victim_valid=1 with victim_way/victim_idx in cycle N+1.
- Back-to-back queries are accepted every cycle. There is no backpressure.
- Touch takes effect at the edge ending the cycle it is presented.
- Touch and query to the same set in the same cycle: the victim is computed from the post-touch state (bypass).
- Touch and query to different sets: independent.
- flush and query in the same cycle: the victim is computed from the all-zero state.
- touch_err pulses in cycle N+1 for a bad touch in cycle N.
- Reset values: victim_valid=0, victim_way=0, victim_idx=0, touch_err=0, all tree state 0.
- Reset asserted mid-query: no victim_valid pulse follows.
- victim_way/victim_idx hold their last value when victim_valid=0.

## Structure
- lc3b_types: add lc3b_plru4 (3-bit, 4-way tree state) for existing 4-way users.
- The state array is a flop array, SETS x (WAYS-1) bits, written by one asynchronous-reset always_ff.
- One sub-module, plru_victim_sel: combinational. Inputs are tree bits and way_valid. Outputs are one-hot and encoded victim. It is instantiated once, on the bypassed state of query_set.
- The touch-update logic is a combinational next-state function inside the top module.

## Test plan
- Reset, then query set 0 with way_valid=4'b1111 -> next cycle victim_valid=1, victim_way=4'b0001, victim_idx=0.
- Touch set 3 way 4'b0001, then query set 3 with all valid -> state 3'b110, victim_way=4'b0100.
- Touch set 1 ways 0,1,2,3 in order -> states 110, 100, 001, 000; final query gives victim_way=4'b0001.
- Query with way_valid=4'b1011 and any tree state -> victim_way=4'b0100, victim_idx=2.
- Same-cycle touch of set 2 way 4'b0100 and query of set 2, starting from 000 -> victim_way=4'b0001 (post-touch state 001).
- touch_way=4'b0110 -> touch_err pulse, state unchanged; flush, then query -> way 0.
- Assert rst_n low mid-query -> no victim_valid pulse.
- WAYS=8 build: after touches 0..7, query -> victim way 0.
